j1soc_rst_ctrl: RTL and testbench
=================================

Name: j1soc_rst_ctrl

Overview:
Parametrised reset sequencer and run-control block for the J1 SoC. It stretches the board reset and releases N reset domains in a staggered order: CPU core, memory, then peripherals/UART. It then supervises the run with a cycle counter, a completion input and a watchdog timeout. The block replaces the fixed "hold reset, run N cycles, stop" sequencing, adds soft-reset re-entry, and reports run status to the SoC and the bench.

Parameters:
N_DOMAINS, 3, number of reset domains; domain 0 is released first (>=1)
HOLD_CYCLES, 5, cycles all domains stay in reset after sys_rst_i falls (>=1)
STAGGER_CYCLES, 4, cycles between successive domain releases (>=1)
TIMEOUT_CYCLES, 40000, RUN cycles before watchdog fires; 0 disables the watchdog
CNT_W, 24, width of all internal counters and cycle_cnt_o; must hold max(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES)

Ports:
sys_clk_i  input  1  system clock; the only clock
sys_rst_i  input  1  reset; synchronous, active-high; overrides everything
sw_rst_req_i  input  1  soft reset request; level sampled on each edge
done_i  input  1  run-complete flag from the CPU/IO map; level sampled
rst_o  output  N_DOMAINS  per-domain reset, active-high, registered
run_o  output  1  high while in RUN
done_o  output  1  sticky: run ended through done_i
timeout_o  output  1  sticky: watchdog fired
cycle_cnt_o  output  CNT_W  number of cycles spent in RUN, registered

Behaviour:
- Reset: when sys_rst_i is sampled 1, the state goes to HOLD and all counters clear. Outputs take these values: rst_o all ones, run_o 0, done_o 0, timeout_o 0, cycle_cnt_o 0.
- Edge E0 is the first rising edge at which sys_rst_i is sampled 0. All timing below is counted from E0.
- States: HOLD, RELEASE, RUN, DONE, TIMEOUT.
- HOLD: the hold counter increments each edge.
  - At edge E0+HOLD_CYCLES, rst_o[0] falls and the state moves to RELEASE (or directly to RUN if N_DOMAINS=1).
- RELEASE: rst_o[k] falls at edge E0+HOLD_CYCLES+k*STAGGER_CYCLES.
  - A released domain never re-asserts except through the reset or timeout paths.
  - At the edge where rst_o[N_DOMAINS-1] falls, the state moves to RUN and run_o rises on that same edge.
- RUN: cycle_cnt_o increments by 1 on each edge while in RUN and saturates at all-ones.
  - done_i sampled 1 -> DONE: run_o 0, done_o 1, cycle_cnt_o frozen, rst_o stays all zero.
  - With TIMEOUT_CYCLES>0, the watchdog fires on the edge where cycle_cnt_o would become TIMEOUT_CYCLES. That edge moves the state to TIMEOUT: run_o 0, timeout_o 1, rst_o all ones, cycle_cnt_o holds TIMEOUT_CYCLES.
  - done_i and watchdog expiry on the same edge: DONE wins, and timeout_o stays 0.
  - done_i is ignored outside RUN.
- DONE and TIMEOUT are terminal. They are left only through sys_rst_i or sw_rst_req_i.
- sw_rst_req_i sampled 1 while sys_rst_i is 0, in any state: the next state is HOLD with identical reset values on all outputs, and that edge becomes a new E0.
  - A request held high keeps the block in HOLD with the hold counter cleared.
  - Counting resumes from the first edge sampled low.
- Priority on any edge: sys_rst_i > sw_rst_req_i > done_i > watchdog > sequencing.
- Every output is driven directly by a flop; there is no combinational path from input to output.
- Illegal parameter values (N_DOMAINS, HOLD_CYCLES or STAGGER_CYCLES equal to 0) are flagged by an elaboration-time check.

Test Plan:
- Default parameters, sys_rst_i high for 5 edges then low (E0 = first low edge) -> rst_o = 3'b111 through E0+4; rst_o[0] falls at E0+5, rst_o[1] at E0+9, rst_o[2] at E0+13; run_o rises at E0+13.
- TIMEOUT_CYCLES=100, done_i held 0 -> timeout_o=1, run_o=0, rst_o=3'b111 and cycle_cnt_o=100 at E0+113, all stable thereafter.
- TIMEOUT_CYCLES=100, done_i pulsed for one cycle, sampled at E0+50 -> done_o=1, run_o=0, cycle_cnt_o=37 from E0+50 onward; rst_o stays 3'b000; timeout never fires.
- done_i sampled 1 on the same edge as watchdog expiry (E0+113, TIMEOUT_CYCLES=100) -> done_o=1, timeout_o=0, rst_o=3'b000.
- sw_rst_req_i pulsed for one cycle at E0+20 during RUN -> rst_o=3'b111, run_o=0, cycle_cnt_o=0 at E0+20; re-release at E0+25, E0+29, E0+33.
- sw_rst_req_i asserted at E0+7 mid-RELEASE and sys_rst_i asserted together with done_i during RUN -> released domains re-assert immediately; sys_rst_i wins and done_o stays 0.

Source files
------------

// File: rtl/j1soc_rst_ctrl.sv
// Reset sequencer and run controller for the J1 SoC: it stretches the board reset,
// releases the reset domains one after another, then supervises the run.
module j1soc_rst_ctrl #(
    parameter int unsigned N_DOMAINS      = 3,
    parameter int unsigned HOLD_CYCLES    = 5,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 40000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_i,
    input  logic                 sw_rst_req_i,
    input  logic                 done_i,
    output logic [N_DOMAINS-1:0] rst_o,
    output logic                 run_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     cycle_cnt_o
);

    if (N_DOMAINS == 0 || HOLD_CYCLES == 0 || STAGGER_CYCLES == 0) begin : g_bad_params
        $fatal(1, "j1soc_rst_ctrl: N_DOMAINS, HOLD_CYCLES and STAGGER_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0]     cycle_cnt_d, cycle_inc;
    logic [N_DOMAINS-1:0] rst_d;
    logic                 run_d, done_d, timeout_d;
    logic                 release_evt;

    always_comb begin
        state_d     = state_q;
        seq_cnt_d   = seq_cnt_q;
        cycle_cnt_d = cycle_cnt_o;
        rst_d       = rst_o;
        run_d       = run_o;
        done_d      = done_o;
        timeout_d   = timeout_o;
        release_evt = 1'b0;
        cycle_inc   = (cycle_cnt_o == '1) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);

        if (sw_rst_req_i) begin
            // The request edge itself counts as the first hold edge (it is the new E0).
            state_d     = ST_HOLD;
            seq_cnt_d   = CNT_W'(1);
            cycle_cnt_d = '0;
            rst_d       = '1;
            run_d       = 1'b0;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (seq_cnt_q == CNT_W'(HOLD_CYCLES)) release_evt = 1'b1;
                    else                                  seq_cnt_d   = seq_cnt_q + CNT_W'(1);
                end
                ST_RELEASE: begin
                    if (seq_cnt_q == CNT_W'(STAGGER_CYCLES - 1)) release_evt = 1'b1;
                    else                                         seq_cnt_d   = seq_cnt_q + CNT_W'(1);
                end
                ST_RUN: begin
                    cycle_cnt_d = cycle_inc;
                    if (done_i) begin
                        state_d = ST_DONE;
                        run_d   = 1'b0;
                        done_d  = 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && cycle_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_d   = ST_TIMEOUT;
                        run_d     = 1'b0;
                        timeout_d = 1'b1;
                        rst_d     = '1;
                    end
                end
                default: ;
            endcase

            // Domains release LSB first, so the reset vector is a shrinking run of ones.
            if (release_evt) begin
                rst_d     = rst_o << 1;
                seq_cnt_d = '0;
                if (rst_d == '0) begin
                    state_d = ST_RUN;
                    run_d   = 1'b1;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= ST_HOLD;
            seq_cnt_q   <= '0;
            cycle_cnt_o <= '0;
            rst_o       <= '1;
            run_o       <= 1'b0;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_cnt_q   <= seq_cnt_d;
            cycle_cnt_o <= cycle_cnt_d;
            rst_o       <= rst_d;
            run_o       <= run_d;
            done_o      <= done_d;
            timeout_o   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_j1soc_rst_ctrl.sv
// Self-checking bench for j1soc_rst_ctrl: directed scenarios with literal expectations,
// then random stimulus against a timeline model based on edges counted since E0.
module tb_j1soc_rst_ctrl;

    localparam int N  = 3;
    localparam int H  = 5;
    localparam int S  = 4;
    localparam int TO = 100;
    localparam int W  = 24;
    localparam int RUN_AT = H + (N - 1) * S;
    localparam logic [N-1:0] ALL_ONES = '1;

    logic          clk = 1'b0;
    logic          sys_rst, sw_rst, done_in;
    logic [N-1:0]  rst_o;
    logic          run_o, done_o, timeout_o;
    logic [W-1:0]  cycle_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    j1soc_rst_ctrl #(
        .N_DOMAINS      (N),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (W)
    ) dut (
        .sys_clk_i    (clk),
        .sys_rst_i    (sys_rst),
        .sw_rst_req_i (sw_rst),
        .done_i       (done_in),
        .rst_o        (rst_o),
        .run_o        (run_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .cycle_cnt_o  (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: d = edges since the current E0 (reset edge gives -1, soft-reset edge gives 0).
    int           d;
    bit           armed = 1'b0;
    bit           m_done, m_to;
    logic [N-1:0] m_rst;
    logic         m_run;
    logic [W-1:0] m_cnt;

    always @(posedge clk) begin
        int rel;
        if (sys_rst || sw_rst) begin
            armed  = 1'b1;
            d      = sys_rst ? -1 : 0;
            m_done = 1'b0;
            m_to   = 1'b0;
            m_rst  = ALL_ONES;
            m_run  = 1'b0;
            m_cnt  = '0;
        end else if (armed) begin
            d++;
            if (!m_done && !m_to) begin
                if (d < RUN_AT) begin
                    rel   = (d < H) ? 0 : (d - H) / S + 1;
                    m_rst = ALL_ONES << rel;
                    m_run = 1'b0;
                end else if (d == RUN_AT) begin
                    m_rst = '0;
                    m_run = 1'b1;
                    m_cnt = '0;
                end else begin
                    m_cnt = W'(d - RUN_AT);
                    if (done_in) begin
                        m_done = 1'b1;
                        m_run  = 1'b0;
                    end else if (TO > 0 && d - RUN_AT == TO) begin
                        m_to  = 1'b1;
                        m_run = 1'b0;
                        m_rst = ALL_ONES;
                    end
                end
            end
        end
        #1;
        if (armed) begin
            chk("m_rst",     32'(rst_o),       32'(m_rst));
            chk("m_run",     32'(run_o),       32'(m_run));
            chk("m_done",    32'(done_o),      32'(m_done));
            chk("m_timeout", 32'(timeout_o),   32'(m_to));
            chk("m_cnt",     32'(cycle_cnt_o), 32'(m_cnt));
        end
    end

    task automatic cyc(input logic r, input logic sw, input logic dn);
        sys_rst = r;
        sw_rst  = sw;
        done_in = dn;
        @(negedge clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        sw_rst  = 1'b0;
        done_in = 1'b0;
        @(negedge clk);

        // Staggered release, then watchdog expiry with done_i held low.
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        chk("reset_rst", 32'(rst_o), 32'h7);
        chk("reset_run", 32'(run_o), 32'h0);
        chk("reset_cnt", 32'(cycle_cnt_o), 32'h0);
        for (int e = 0; e <= 116; e++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (e == 4)  chk("hold_e4_rst", 32'(rst_o), 32'h7);
            if (e == 5)  chk("rel0_e5_rst", 32'(rst_o), 32'h6);
            if (e == 8)  chk("rel0_e8_rst", 32'(rst_o), 32'h6);
            if (e == 9)  chk("rel1_e9_rst", 32'(rst_o), 32'h4);
            if (e == 12) chk("e12_run", 32'(run_o), 32'h0);
            if (e == 13) begin
                chk("rel2_e13_rst", 32'(rst_o), 32'h0);
                chk("rel2_e13_run", 32'(run_o), 32'h1);
            end
            if (e == 112) chk("wd_e112_timeout", 32'(timeout_o), 32'h0);
            if (e == 113 || e == 116) begin
                chk("wd_timeout", 32'(timeout_o), 32'h1);
                chk("wd_run", 32'(run_o), 32'h0);
                chk("wd_rst", 32'(rst_o), 32'h7);
                chk("wd_cnt", 32'(cycle_cnt_o), 32'd100);
            end
        end

        // One-cycle done pulse sampled at E0+50.
        cyc(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 130; e++) begin
            cyc(1'b0, 1'b0, e == 50);
            if (e == 50 || e == 130) begin
                chk("done50_done", 32'(done_o), 32'h1);
                chk("done50_run", 32'(run_o), 32'h0);
                chk("done50_cnt", 32'(cycle_cnt_o), 32'd37);
                chk("done50_rst", 32'(rst_o), 32'h0);
                chk("done50_timeout", 32'(timeout_o), 32'h0);
            end
        end

        // done_i on the watchdog-expiry edge.
        cyc(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 115; e++) begin
            cyc(1'b0, 1'b0, e == 113);
            if (e == 113 || e == 115) begin
                chk("tie_done", 32'(done_o), 32'h1);
                chk("tie_timeout", 32'(timeout_o), 32'h0);
                chk("tie_rst", 32'(rst_o), 32'h0);
                chk("tie_cnt", 32'(cycle_cnt_o), 32'd100);
            end
        end

        // Soft reset pulse during RUN at E0+20.
        cyc(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 40; e++) begin
            cyc(1'b0, e == 20, 1'b0);
            if (e == 20) begin
                chk("sw20_rst", 32'(rst_o), 32'h7);
                chk("sw20_run", 32'(run_o), 32'h0);
                chk("sw20_cnt", 32'(cycle_cnt_o), 32'h0);
            end
            if (e == 24) chk("sw_e24_rst", 32'(rst_o), 32'h7);
            if (e == 25) chk("sw_e25_rst", 32'(rst_o), 32'h6);
            if (e == 29) chk("sw_e29_rst", 32'(rst_o), 32'h4);
            if (e == 33) begin
                chk("sw_e33_rst", 32'(rst_o), 32'h0);
                chk("sw_e33_run", 32'(run_o), 32'h1);
            end
        end

        // Soft reset mid-RELEASE, then sys_rst together with done_i during RUN.
        cyc(1'b1, 1'b0, 1'b0);
        for (int e = 0; e <= 30; e++) begin
            cyc(1'b0, e == 7, 1'b0);
            if (e == 6)  chk("swrel_e6_rst", 32'(rst_o), 32'h6);
            if (e == 7)  chk("swrel_e7_rst", 32'(rst_o), 32'h7);
            if (e == 12) chk("swrel_e12_rst", 32'(rst_o), 32'h6);
            if (e == 30) chk("swrel_e30_run", 32'(run_o), 32'h1);
        end
        cyc(1'b1, 1'b0, 1'b1);
        chk("rstdone_done", 32'(done_o), 32'h0);
        chk("rstdone_rst", 32'(rst_o), 32'h7);
        chk("rstdone_run", 32'(run_o), 32'h0);

        // Random traffic across all paths.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0,
                $urandom_range(0, 89) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
